// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample FIFO: default sizing and the
// encoding of the output sequencer states.
package audio_pkg;

  localparam int WL_DEFAULT    = 16;
  localparam int DEPTH_DEFAULT = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND_L = 2'd1;
  localparam logic [1:0] SEND_R = 2'd2;

endpackage

// File: rtl/asf_sync_fifo.sv
// Single-clock FIFO holding stereo pairs; DEPTH must be a power of two so the
// pointers wrap on their own. Read data is the head entry, shown combinationally.
module asf_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_level;
  logic          w_doPush;
  logic          w_doPop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_doPop  = i_pop && (r_level != '0);
  assign w_doPush = i_push && ((r_level != LEVEL_FULL) || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_level = r_level;

endmodule

// File: rtl/audio_sample_fifo.sv
// Buffers stereo pairs from an audio receiver and serialises them as L then R
// words on a valid/ready stream. Define AUDIO_SAMPLE_FIFO_OVF_CNT_EN to build the dropped-pair counter.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int WL    = WL_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WL-1:0]        audio_left_i,
  input  logic signed [WL-1:0]        audio_right_i,
  input  logic                        audio_rx_down,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [WL-1:0]        m_data,
  output logic                        m_chan,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        ovf_flag,
  input  logic                        ovf_clr,
  output logic [15:0]                 ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [1:0]           r_state;
  logic                 r_valid;
  logic                 r_chan;
  logic signed [WL-1:0] r_data;
  logic signed [WL-1:0] r_heldRight;
  logic                 r_ovfFlag;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_notEmpty;
  logic [2*WL-1:0]      w_rdPair;
  logic [AW:0]          w_level;

  asf_sync_fifo #(
    .W     (2*WL),
    .DEPTH (DEPTH)
  ) u_pairFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({audio_left_i, audio_right_i}),
    .i_pop   (w_pop),
    .o_rdata (w_rdPair),
    .o_level (w_level)
  );

  assign w_notEmpty = (w_level != '0);
  assign w_full     = (w_level == LEVEL_FULL);
  assign w_push     = audio_rx_down && (!w_full || w_pop);
  assign w_drop     = audio_rx_down && w_full && !w_pop;

  // A pair leaves the FIFO when the sequencer is idle, or as the right word is taken.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = w_notEmpty;
      SEND_R:  w_pop = m_ready && w_notEmpty;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_chan      <= 1'b0;
      r_heldRight <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state     <= SEND_L;
            r_valid     <= 1'b1;
            r_data      <= w_rdPair[2*WL-1:WL];
            r_chan      <= 1'b0;
            r_heldRight <= w_rdPair[WL-1:0];
          end
        end
        SEND_L: begin
          if (m_ready) begin
            r_state <= SEND_R;
            r_data  <= r_heldRight;
            r_chan  <= 1'b1;
          end
        end
        SEND_R: begin
          if (m_ready) begin
            if (w_pop) begin
              r_state     <= SEND_L;
              r_data      <= w_rdPair[2*WL-1:WL];
              r_chan      <= 1'b0;
              r_heldRight <= w_rdPair[WL-1:0];
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfFlag <= 1'b0;
    end else if (w_drop) begin
      r_ovfFlag <= 1'b1;
    end else if (ovf_clr) begin
      r_ovfFlag <= 1'b0;
    end
  end

`ifdef AUDIO_SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0] r_ovfCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfCnt <= '0;
    end else if (w_drop) begin
      if (r_ovfCnt != 16'hFFFF) begin
        r_ovfCnt <= r_ovfCnt + 16'd1;
      end
    end else if (ovf_clr) begin
      r_ovfCnt <= '0;
    end
  end

  assign ovf_cnt = r_ovfCnt;
`else
  assign ovf_cnt = 16'd0;
`endif

  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign m_chan     = r_chan;
  assign fifo_level = w_level;
  assign ovf_flag   = r_ovfFlag;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed latency/backpressure/fill
// scenarios plus a randomized stream checked against a queue of expected words.
module tb_audio_sample_fifo;

  localparam int WL    = 16;
  localparam int DEPTH = 16;
`ifdef AUDIO_SAMPLE_FIFO_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] audio_left_i;
  logic [WL-1:0] audio_right_i;
  logic          audio_rx_down;
  logic          m_valid;
  logic          m_ready;
  logic [WL-1:0] m_data;
  logic          m_chan;
  logic [4:0]    fifo_level;
  logic          ovf_flag;
  logic          ovf_clr;
  logic [15:0]   ovf_cnt;

  int checks   = 0;
  int failures = 0;

  // Expected output words as {chan, data}, oldest first.
  logic [WL:0] expQ[$];

  always #5 clk = ~clk;

  audio_sample_fifo #(.WL(WL), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .audio_left_i  (audio_left_i),
    .audio_right_i (audio_right_i),
    .audio_rx_down (audio_rx_down),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_chan        (m_chan),
    .fifo_level    (fifo_level),
    .ovf_flag      (ovf_flag),
    .ovf_clr       (ovf_clr),
    .ovf_cnt       (ovf_cnt)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    audio_rx_down = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drivePair(input logic [WL-1:0] l, input logic [WL-1:0] r);
    audio_left_i  = l;
    audio_right_i = r;
    audio_rx_down = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    drivePair(16'h5A5A, 16'hC3C3);
    step();
    audio_rx_down = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0000", m_data); end
    checks++; if (m_chan !== 1'b0) begin failures++; $display("[TB] FAIL reset_chan: got %0b expected 0", m_chan); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf_flag: got %0b expected 0", ovf_flag); end
    checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_pair();
    doReset();
    m_ready = 1'b1;
    drivePair(16'h1234, 16'hABCD);
    step();
    audio_rx_down = 1'b0;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_t1: got %0b expected 0", m_valid); end
    checks++; if (fifo_level !== 5'd1) begin failures++; $display("[TB] FAIL single_level_t1: got %0d expected 1", fifo_level); end
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b0, 16'h1234}) begin failures++; $display("[TB] FAIL single_left_t2: got valid=%0b chan=%0b data=%h expected 1/0/1234", m_valid, m_chan, m_data); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL single_level_t2: got %0d expected 0", fifo_level); end
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b1, 16'hABCD}) begin failures++; $display("[TB] FAIL single_right_t3: got valid=%0b chan=%0b data=%h expected 1/1/abcd", m_valid, m_chan, m_data); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_t4: got %0b expected 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [WL:0]   words [6];
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    doReset();
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        l = 16'($urandom);
        r = 16'($urandom);
        words[2*c]   = {1'b0, l};
        words[2*c+1] = {1'b1, r};
        drivePair(l, r);
      end else begin
        audio_rx_down = 1'b0;
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if ({m_valid, m_chan, m_data} !== {1'b1, words[c-2]}) begin
          failures++;
          $display("[TB] FAIL b2b_word%0d: got valid=%0b chan=%0b data=%h expected valid=1 word=%h", c-2, m_valid, m_chan, m_data, words[c-2]);
        end
      end
      if (c == 8) begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got %0b expected 0", m_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    doReset();
    l = 16'($urandom);
    r = 16'($urandom);
    drivePair(l, r);
    step();
    audio_rx_down = 1'b0;
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b0, l}) begin failures++; $display("[TB] FAIL bp_first: got valid=%0b chan=%0b data=%h expected 1/0/%h", m_valid, m_chan, m_data, l); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b0, l}) begin failures++; $display("[TB] FAIL bp_hold%0d: got valid=%0b chan=%0b data=%h expected 1/0/%h", k, m_valid, m_chan, m_data, l); end
    end
    m_ready = 1'b1;
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b1, r}) begin failures++; $display("[TB] FAIL bp_right: got valid=%0b chan=%0b data=%h expected 1/1/%h", m_valid, m_chan, m_data, r); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle: got %0b expected 0", m_valid); end
  endtask

  // A primer pair parks in the output stage first, so 18 strobes see 16 free slots.
  task automatic test_fill();
    logic [WL-1:0] pl;
    logic [WL-1:0] pr;
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    logic [WL:0]   exp;
    int            expCnt;
    doReset();
    expQ.delete();
    pl = 16'($urandom);
    pr = 16'($urandom);
    drivePair(pl, pr);
    step();
    audio_rx_down = 1'b0;
    step();
    checks++; if ({m_valid, m_data} !== {1'b1, pl}) begin failures++; $display("[TB] FAIL fill_primer: got valid=%0b data=%h expected 1/%h", m_valid, m_data, pl); end
    for (int i = 1; i <= 18; i++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      drivePair(l, r);
      if (i <= DEPTH) begin
        expQ.push_back({1'b0, l});
        expQ.push_back({1'b1, r});
      end
      step();
      if (i == DEPTH) begin
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL fill_level_full: got %0d expected 16", fifo_level); end
        checks++; if (ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL fill_no_ovf_yet: got %0b expected 0", ovf_flag); end
      end
      if (i == DEPTH + 1) begin
        checks++; if (ovf_flag !== 1'b1) begin failures++; $display("[TB] FAIL fill_ovf_next_cycle: got %0b expected 1", ovf_flag); end
      end
    end
    audio_rx_down = 1'b0;
    step();
    expCnt = CNT_EN ? 2 : 0;
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL fill_level_after: got %0d expected 16", fifo_level); end
    checks++; if (ovf_flag !== 1'b1) begin failures++; $display("[TB] FAIL fill_ovf_flag: got %0b expected 1", ovf_flag); end
    checks++; if (ovf_cnt !== 16'(expCnt)) begin failures++; $display("[TB] FAIL fill_ovf_cnt: got %0d expected %0d", ovf_cnt, expCnt); end

    drivePair(16'($urandom), 16'($urandom));
    ovf_clr = 1'b1;
    step();
    audio_rx_down = 1'b0;
    ovf_clr = 1'b0;
    expCnt = CNT_EN ? 3 : 0;
    checks++; if (ovf_flag !== 1'b1) begin failures++; $display("[TB] FAIL ovf_beats_clr_flag: got %0b expected 1", ovf_flag); end
    checks++; if (ovf_cnt !== 16'(expCnt)) begin failures++; $display("[TB] FAIL ovf_beats_clr_cnt: got %0d expected %0d", ovf_cnt, expCnt); end

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL clr_flag: got %0b expected 0", ovf_flag); end
    checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("[TB] FAIL clr_cnt: got %0d expected 0", ovf_cnt); end

    m_ready = 1'b1;
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b1, pr}) begin failures++; $display("[TB] FAIL fill_primer_right: got valid=%0b chan=%0b data=%h expected 1/1/%h", m_valid, m_chan, m_data, pr); end
    l = 16'($urandom);
    r = 16'($urandom);
    drivePair(l, r);
    expQ.push_back({1'b0, l});
    expQ.push_back({1'b1, r});
    step();
    audio_rx_down = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL full_push_pop_level: got %0d expected 16", fifo_level); end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL full_push_pop_flag: got %0b expected 0", ovf_flag); end

    for (int b = 0; b < 100 && expQ.size() > 0; b++) begin
      if (m_valid === 1'b1) begin
        exp = expQ.pop_front();
        checks++;
        if ({m_chan, m_data} !== exp) begin
          failures++;
          $display("[TB] FAIL fill_drain_order: got chan=%0b data=%h expected chan=%0b data=%h", m_chan, m_data, exp[WL], exp[WL-1:0]);
        end
      end
      step();
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL fill_drain_timeout: got %0d words missing expected 0", expQ.size()); end
    checks++; if ({m_valid, fifo_level} !== {1'b0, 5'd0}) begin failures++; $display("[TB] FAIL fill_drained: got valid=%0b level=%0d expected 0/0", m_valid, fifo_level); end
  endtask

  task automatic test_reset_mid();
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    doReset();
    for (int i = 0; i < 4; i++) begin
      drivePair(16'($urandom), 16'($urandom));
      step();
    end
    audio_rx_down = 1'b0;
    checks++; if (fifo_level !== 5'd3) begin failures++; $display("[TB] FAIL rstmid_level_pre: got %0d expected 3", fifo_level); end
    m_ready = 1'b1;
    step();
    checks++; if ({m_valid, m_chan} !== 2'b11) begin failures++; $display("[TB] FAIL rstmid_in_right: got valid=%0b chan=%0b expected 1/1", m_valid, m_chan); end
    rst = 1'b1;
    m_ready = 1'b0;
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b0, 1'b0, 16'h0}) begin failures++; $display("[TB] FAIL rstmid_outputs: got valid=%0b chan=%0b data=%h expected 0/0/0000", m_valid, m_chan, m_data); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL rstmid_level: got %0d expected 0", fifo_level); end
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_partial%0d: got %0b expected 0", k, m_valid); end
    end
    l = 16'($urandom);
    r = 16'($urandom);
    drivePair(l, r);
    step();
    audio_rx_down = 1'b0;
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b0, l}) begin failures++; $display("[TB] FAIL rstmid_new_left: got valid=%0b chan=%0b data=%h expected 1/0/%h", m_valid, m_chan, m_data, l); end
    step();
    checks++; if ({m_valid, m_chan, m_data} !== {1'b1, 1'b1, r}) begin failures++; $display("[TB] FAIL rstmid_new_right: got valid=%0b chan=%0b data=%h expected 1/1/%h", m_valid, m_chan, m_data, r); end
  endtask

  // 40 pairs at random spacing against a randomly stalling consumer; pointers wrap twice.
  task automatic test_wrap();
    int            received;
    logic          prevValid;
    logic          prevReady;
    logic [WL-1:0] prevData;
    logic          prevChan;
    logic [WL:0]   exp;
    doReset();
    expQ.delete();
    received = 0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int gap;
          gap = int'($urandom_range(0, 4));
          repeat (gap) step();
          drivePair(16'($urandom), 16'($urandom));
          expQ.push_back({1'b0, audio_left_i});
          expQ.push_back({1'b1, audio_right_i});
          step();
          audio_rx_down = 1'b0;
        end
      end
      begin
        prevValid = 1'b0;
        prevReady = 1'b1;
        prevData  = '0;
        prevChan  = 1'b0;
        for (int b = 0; b < 2000 && received < 80; b++) begin
          if (prevValid && !prevReady) begin
            checks++;
            if ({m_valid, m_chan, m_data} !== {1'b1, prevChan, prevData}) begin
              failures++;
              $display("[TB] FAIL wrap_hold: got valid=%0b chan=%0b data=%h expected 1/%0b/%h", m_valid, m_chan, m_data, prevChan, prevData);
            end
          end
          m_ready = ($urandom_range(0, 3) != 0);
          if (m_valid === 1'b1 && m_ready) begin
            checks++;
            if (expQ.size() == 0) begin
              failures++;
              $display("[TB] FAIL wrap_extra_word: got chan=%0b data=%h expected no word", m_chan, m_data);
            end else begin
              exp = expQ.pop_front();
              if ({m_chan, m_data} !== exp) begin
                failures++;
                $display("[TB] FAIL wrap_word%0d: got chan=%0b data=%h expected chan=%0b data=%h", received, m_chan, m_data, exp[WL], exp[WL-1:0]);
              end
            end
            received++;
          end
          prevValid = m_valid;
          prevReady = m_ready;
          prevData  = m_data;
          prevChan  = m_chan;
          step();
        end
      end
    join
    checks++; if (received != 80) begin failures++; $display("[TB] FAIL wrap_count: got %0d words expected 80", received); end
    m_ready = 1'b1;
    step();
    checks++; if ({m_valid, fifo_level, ovf_flag} !== {1'b0, 5'd0, 1'b0}) begin failures++; $display("[TB] FAIL wrap_end_state: got valid=%0b level=%0d ovf=%0b expected 0/0/0", m_valid, fifo_level, ovf_flag); end
  endtask

  initial begin
    rst = 1'b1;
    audio_left_i = '0;
    audio_right_i = '0;
    audio_rx_down = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_backpressure();
    test_fill();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter WL, default 16: audio word length in bits.
REQ-002 Parameter DEPTH, default 16: FIFO depth in stereo pairs; must be a power of two, minimum 2.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 audio_left_i  input  WL  signed left sample; stable while audio_rx_down is high.
REQ-006 audio_right_i  input  WL  signed right sample; stable while audio_rx_down is high.
REQ-007 audio_rx_down  input  1  one-cycle strobe in clk domain meaning a new stereo pair is ready.
REQ-008 m_valid  output  1  output word valid.
REQ-009 m_ready  input  1  downstream accepts the word.
REQ-010 m_data  output  WL  signed output sample.
REQ-011 m_chan  output  1  channel of m_data: 0 = left, 1 = right.
REQ-012 fifo_level  output  log2(DEPTH)+1  number of stored pairs.
REQ-013 ovf_flag  output  1  sticky flag: a pair was dropped.
REQ-014 ovf_clr  input  1  clears ovf_flag (and ovf_cnt when present).
REQ-015 ovf_cnt  output  16  count of dropped pairs.

Function
REQ-016 On audio_rx_down, the block SHALL write {audio_left_i, audio_right_i} into the FIFO if fifo_level < DEPTH, or if a pop occurs in the same cycle.
REQ-017 On audio_rx_down with the FIFO full and no pop in the same cycle, the pair SHALL be dropped, ovf_flag SHALL be set on the next cycle, and FIFO contents SHALL be unchanged.
REQ-018 The output FSM SHALL have the states IDLE, SEND_L and SEND_R.
REQ-019 IDLE: when fifo_level > 0, the FSM SHALL pop one pair into a holding register and go to SEND_L; m_valid = 0 in IDLE.
REQ-020 SEND_L: m_valid = 1, m_data = held left sample, m_chan = 0; on m_ready the FSM SHALL go to SEND_R.
REQ-021 SEND_R: m_valid = 1, m_data = held right sample, m_chan = 1; on m_ready, if fifo_level > 0, the FSM SHALL pop the next pair in the same cycle and go to SEND_L, otherwise go to IDLE.
REQ-022 m_data and m_chan SHALL NOT change while m_valid is high and m_ready is low.
REQ-023 Latency: a strobe at cycle t into an empty FIFO with the FSM in IDLE SHALL give m_valid = 1 (left word) at t+2.
REQ-024 Back-to-back throughput SHALL be one word per cycle with m_ready held high.
REQ-025 fifo_level SHALL be updated one cycle after the push or pop and SHALL equal pushes minus pops.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 If ovf_clr and an overflow event occur in the same cycle, the overflow SHALL take priority: the flag ends set.
REQ-028 Stored samples SHALL be bit-exact; no arithmetic is applied.

Reset
REQ-029 While rst is high, the block SHALL force: pointers = 0, fifo_level = 0, FSM = IDLE, m_valid = 0, m_data = 0, m_chan = 0, ovf_flag = 0, ovf_cnt = 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held pair and all FIFO contents; no partial pair is output after reset.
REQ-031 FIFO storage RAM need not be reset.

Configuration
REQ-032 Macro AUDIO_SAMPLE_FIFO_OVF_CNT_EN.
- Defined: ovf_cnt increments by 1 on each dropped pair, saturates at 16'hFFFF, and clears on ovf_clr (overflow takes priority as in REQ-027).
- Undefined: ovf_cnt is driven constant 0 and no counter logic is built.

Structure
REQ-033 Shared package audio_pkg SHALL hold the default WL, the default DEPTH and the FSM state encoding (IDLE = 2'd0, SEND_L = 2'd1, SEND_R = 2'd2).
REQ-034 Pair storage SHALL be one sub-module, asf_sync_fifo (width 2*WL, depth DEPTH, push/pop/level ports); the FSM, overflow logic and output registers stay in the top module.

Verification
REQ-035 Single pair: L = 16'h1234, R = 16'hABCD strobed at t, m_ready = 1 -> m_valid at t+2 with (1234, chan 0), then t+3 with (ABCD, chan 1), then IDLE.
REQ-036 Backpressure: m_ready = 0 for 5 cycles in SEND_L -> m_data and m_chan hold; release -> L then R in order.
REQ-037 Fill: m_ready = 0 from start, 18 pairs strobed (DEPTH = 16) -> fifo_level = 16, ovf_flag = 1, ovf_cnt = 2 with macro (0 without), first 16 pairs output in order after release.
REQ-038 Full with simultaneous strobe and pop -> pair accepted, ovf_flag unchanged, fifo_level stays 16.
REQ-039 Wrap: 40 pairs streamed at random strobe spacing, m_ready random -> output sequence matches the input scoreboard exactly.
REQ-040 Reset asserted in SEND_R with 3 pairs queued -> next cycle m_valid = 0, fifo_level = 0; a new pair after reset is output correctly.
